pm4_share_arb: RTL and testbench
================================

// Module: pm4_share_arb
// PURPOSE
//  Shares one pm4 4x4 unsigned multiplier among NREQ requesters with round-robin arbitration.
//  Two-stage pipeline: grant/operand register -> pm4 (combinational) -> result register.
//  Valid/ready handshakes on every requester port and on the single response port.
//  The response carries the requester ID. Sits between the requester blocks and the shared pm4 datapath.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  IDW   2   width of requester ID; must equal clog2(NREQ)
//  CNTW  16  width of completed-operation counter
// PORTS
//  clk        in   1       clock; all state on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   NREQ    request i has operands
//  req_ready  out  NREQ    one-hot grant; handshake on req_valid[i] & req_ready[i]
//  req_a      in   4*NREQ  operand a of requester i at [4i+3:4i]
//  req_b      in   4*NREQ  operand b of requester i at [4i+3:4i]
//  rsp_valid  out  1       result valid
//  rsp_ready  in   1       consumer accepts result
//  rsp_id     out  IDW     requester that issued this result
//  rsp_c      out  8       a*b, unsigned, full 8-bit product
//  ops_done   out  CNTW    count of completed response handshakes
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_id=0, rsp_c=0, ops_done=0, s1_vld=0, op regs=0, rr_ptr=0.
//   Async reset mid-operation discards all in-flight work.
//  Stage ready: s2_rdy = !rsp_valid | rsp_ready; s1_rdy = !s1_vld | s2_rdy.
//  Grant: when s1_rdy, grant the first i with req_valid[i], searching from rr_ptr upward mod NREQ.
//   req_ready is combinational and at most one bit is set. req_ready=0 when !s1_rdy.
//   req_ready never depends on req_valid of the same index beyond the search.
//  On grant of i: op_a/op_b <= req_a/b[i]; op_id <= i; s1_vld <= 1; rr_ptr <= (i+1) mod NREQ.
//   No grant: rr_ptr holds.
//  If s1_rdy and no grant: s1_vld <= 0.
//  If s1_vld & s2_rdy: rsp_c <= pm4(op_a,op_b); rsp_id <= op_id; rsp_valid <= 1.
//   Else if rsp_ready: rsp_valid <= 0.
//  Latency: grant at edge N -> rsp_valid at edge N+2 (no stall).
//   Full throughput is 1 op/cycle with rsp_ready held high.
//  Backpressure: rsp_valid=1 & rsp_ready=0 holds rsp_* stable and stalls s1.
//   New grants are allowed only if s1 is empty, so at most 2 ops are in flight.
//  Simultaneous rsp handshake and s1 advance in one cycle: new result loaded, rsp_valid stays 1.
//  ops_done += 1 on each rsp_valid & rsp_ready; wraps modulo 2^CNTW.
//  Fairness: with all NREQ requesting continuously, grants are 0,1,..,NREQ-1,0,...
//   No requester waits more than NREQ grants.
//  Products: 15*15=225 max; no overflow and no truncation.
// CONFIGURATION
//  OPERAND_GATE_EN defined: op_a/op_b load only on a grant and otherwise hold.
//   pm4 inputs do not toggle while idle or stalled (power-analysis build).
//  OPERAND_GATE_EN undefined: op_a/op_b load every cycle s1_rdy=1.
//   With no grant they load requester rr_ptr's operands.
//  Functional outputs are identical in both builds; only internal toggle activity differs.
// STRUCTURE
//  Shared package pm4_pkg: PM4_OPW=4, PM4_RESW=8, and typedef for the {id,a,b} op record.
//  One sub-module, pm4_rr_pick: combinational round-robin picker.
//   Inputs: req vector, rr_ptr, enable. Outputs: one-hot grant and encoded index.
//  Existing pm4 is instantiated once, unmodified, as the datapath.
// TESTING
//  Reset mid-run: pull rst_n low with 2 ops in flight.
//   -> rsp_valid=0 and ops_done=0 immediately; next grant goes to requester 0.
//  Single requester 1: a=2, b=4.
//   -> req_ready[1] the same cycle; 2 edges later rsp_valid=1, rsp_c=8, rsp_id=1.
//  All 4 requesters valid with (10,5), (14,7), (15,3), (2,4), rsp_ready=1.
//   -> results 50, 98, 45, 8 with ids 0..3 on consecutive cycles; ops_done=4.
//  Backpressure: rsp_ready=0 for 5 cycles with all valid.
//   -> rsp_c is held, exactly 2 ops in flight, req_ready=0.
//   On release, results drain in order with none lost or duplicated.
//  Fairness: requesters 0 and 3 valid continuously for 20 grants.
//   -> grants alternate 0,3,0,3...; each gets 10.
//  Counter wrap: CNTW=4, 17 completed ops -> ops_done=1.
//  Edge operands 15*15 -> 225 and 0*9 -> 0; run both builds with OPERAND_GATE_EN and without.

Source files
------------

// File: rtl/pm4_pkg.sv
// Shared pm4 datapath constants and the operation record.
// Used by the arbiter and its round-robin picker.
package pm4_pkg;

   localparam int PM4_OPW     = 4;
   localparam int PM4_RESW    = 8;
   localparam int PM4_IDW_MAX = 3;

   typedef struct packed {
      logic [PM4_IDW_MAX-1:0] id;
      logic [PM4_OPW-1:0]     a;
      logic [PM4_OPW-1:0]     b;
   } pm4_op_t;

endpackage

// File: rtl/pm4_share_arb_if.sv
// Requester and response handshake bundle for pm4_share_arb.
// master = requesters/consumer side, slave = arbiter side.
interface pm4_share_arb_if
   import pm4_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [PM4_OPW*NREQ-1:0] req_a;
   logic [PM4_OPW*NREQ-1:0] req_b;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [IDW-1:0]          rsp_id;
   logic [PM4_RESW-1:0]     rsp_c;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_c
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_c
   );

endinterface

// File: rtl/pm4.sv
// Existing pm4 datapath: 4x4 unsigned multiplier, combinational.
// Full 8-bit product, 15*15=225 fits without truncation.
module pm4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   assign p = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/pm4_rr_pick.sv
// Combinational round-robin picker: first requester at or above
// ptr (mod NREQ) wins; one-hot grant plus encoded index.
module pm4_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   // scan offsets high-to-low so the nearest requester is written last
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (en && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
               idx = IDW'(i);
               any = 1'b1;
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = any && (idx == IDW'(i));
      end
   end

endmodule

// File: rtl/pm4_share_arb.sv
// Round-robin sharing of one pm4 multiplier among NREQ requesters.
// OPERAND_GATE_EN: operand regs load only on a grant (quiet pm4 inputs).
module pm4_share_arb
   import pm4_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   pm4_share_arb_if.slave  bus,
   output logic [CNTW-1:0] ops_done
);

   logic                s1_vld;
   pm4_op_t             op_q;
   logic [IDW-1:0]      rr_ptr;
   logic                rsp_valid_q;
   logic [IDW-1:0]      rsp_id_q;
   logic [PM4_RESW-1:0] rsp_c_q;

   logic                s1_rdy;
   logic                s2_rdy;
   logic [NREQ-1:0]     gnt;
   logic [IDW-1:0]      gnt_idx;
   logic                gnt_any;
   logic [IDW-1:0]      sel;
   logic [IDW-1:0]      rr_nxt;
   logic [PM4_OPW-1:0]  a_mux;
   logic [PM4_OPW-1:0]  b_mux;
   logic [PM4_RESW-1:0] prod;
   logic                unused_id_bits;

   assign s2_rdy = !rsp_valid_q || bus.rsp_ready;
   assign s1_rdy = !s1_vld || s2_rdy;

   pm4_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr),
      .en  (s1_rdy),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   assign bus.req_ready = gnt;

   // operand mux follows the grant, else the pointed-at requester
   always_comb begin
      sel    = gnt_any ? gnt_idx : rr_ptr;
      rr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      a_mux  = '0;
      b_mux  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel == IDW'(i)) begin
            a_mux = bus.req_a[i*PM4_OPW +: PM4_OPW];
            b_mux = bus.req_b[i*PM4_OPW +: PM4_OPW];
         end
      end
   end

   pm4 u_pm4 (
      .a (op_q.a),
      .b (op_q.b),
      .p (prod)
   );

   // stage 1: grant capture, operand register, round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         op_q   <= '0;
         rr_ptr <= '0;
      end else begin
         if (s1_rdy) begin
            s1_vld <= gnt_any;
         end
         if (gnt_any) begin
            op_q.id <= PM4_IDW_MAX'(gnt_idx);
            rr_ptr  <= rr_nxt;
         end
`ifdef OPERAND_GATE_EN
         if (gnt_any) begin
            op_q.a <= a_mux;
            op_q.b <= b_mux;
         end
`else
         if (s1_rdy) begin
            op_q.a <= a_mux;
            op_q.b <= b_mux;
         end
`endif
      end
   end

   // stage 2: result register with backpressure hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_c_q     <= '0;
      end else if (s1_vld && s2_rdy) begin
         rsp_valid_q <= 1'b1;
         rsp_id_q    <= op_q.id[IDW-1:0];
         rsp_c_q     <= prod;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // completed response handshakes, wrapping counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_done <= '0;
      end else if (rsp_valid_q && bus.rsp_ready) begin
         ops_done <= ops_done + CNTW'(1);
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_c      = rsp_c_q;
   assign unused_id_bits = &{1'b0, op_q.id};

endmodule

// File: tb/tb_pm4_share_arb.sv
// Directed bench for pm4_share_arb: latency, ordering,
// backpressure, fairness, reset and counter wrap.
module tb_pm4_share_arb;

   logic        clk;
   logic        rst_n;
   logic [15:0] ops_done;
   logic [3:0]  ops_done4;

   int n_chk;
   int n_err;

   pm4_share_arb_if #(.NREQ(4), .IDW(2)) bus ();
   pm4_share_arb_if #(.NREQ(4), .IDW(2)) bus4 ();

   pm4_share_arb #(
      .NREQ (4),
      .IDW  (2),
      .CNTW (16)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .ops_done (ops_done)
   );

   pm4_share_arb #(
      .NREQ (4),
      .IDW  (2),
      .CNTW (4)
   ) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus4),
      .ops_done (ops_done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [3:0] a,
                         input logic [3:0] b);
      bus.req_a[i*4 +: 4] = a;
      bus.req_b[i*4 +: 4] = b;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          exp_c [4];
      logic [3:0]  m;
      logic [3:0]  oh;
      int          cnt0;
      int          cnt3;

      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.rsp_ready  = 1'b0;
      bus4.req_valid = '0;
      bus4.req_a     = '0;
      bus4.req_b     = '0;
      bus4.rsp_ready = 1'b0;

      #12;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_c", 32'(bus.rsp_c), 32'd0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_ops_done4", 32'(ops_done4), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // single requester 1: 2*4
      bus.rsp_ready = 1'b1;
      set_op(1, 4'd2, 4'd4);
      bus.req_valid = 4'b0010;
      #1;
      chk("single_gnt", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = '0;
      chk("single_lat1", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("single_valid", 32'(bus.rsp_valid), 32'd1);
      chk("single_c", 32'(bus.rsp_c), 32'd8);
      chk("single_id", 32'(bus.rsp_id), 32'd1);
      tick();
      chk("single_drain", 32'(bus.rsp_valid), 32'd0);
      chk("single_ops", 32'(ops_done), 32'd1);

      // reset with two ops in flight
      bus.rsp_ready = 1'b0;
      set_op(0, 4'd3, 4'd3);
      set_op(1, 4'd4, 4'd4);
      set_op(2, 4'd5, 4'd5);
      set_op(3, 4'd6, 4'd6);
      bus.req_valid = 4'b1111;
      tick();
      bus.req_valid = 4'b1101;
      tick();
      chk("mid_inflight", 32'(bus.rsp_valid), 32'd1);
      chk("mid_stall_gnt", 32'(bus.req_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_ops", 32'(ops_done), 32'd0);
      chk("mid_rst_next_gnt", 32'(bus.req_ready), 32'b0001);
      bus.req_valid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // all four requesting, full throughput
      bus.rsp_ready = 1'b1;
      set_op(0, 4'd10, 4'd5);
      set_op(1, 4'd14, 4'd7);
      set_op(2, 4'd15, 4'd3);
      set_op(3, 4'd2, 4'd4);
      exp_c = '{50, 98, 45, 8};
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            m = 4'hF;
            m = m << k;
            oh = 4'b0001;
            oh = oh << k;
            bus.req_valid = m;
            #1;
            chk("all4_gnt", 32'(bus.req_ready), 32'(oh));
         end else begin
            bus.req_valid = '0;
         end
         tick();
         if (k >= 1 && k <= 4) begin
            chk("all4_valid", 32'(bus.rsp_valid), 32'd1);
            chk("all4_c", 32'(bus.rsp_c), 32'(exp_c[k-1]));
            chk("all4_id", 32'(bus.rsp_id), 32'(k - 1));
         end
      end
      chk("all4_ops", 32'(ops_done), 32'd4);

      // backpressure with all valid
      bus.rsp_ready = 1'b0;
      set_op(0, 4'd15, 4'd15);
      set_op(1, 4'd0, 4'd9);
      set_op(2, 4'd7, 4'd8);
      set_op(3, 4'd3, 4'd5);
      bus.req_valid = 4'b1111;
      #1;
      chk("bp_gnt0", 32'(bus.req_ready), 32'b0001);
      tick();
      bus.req_valid = 4'b1110;
      #1;
      chk("bp_gnt1", 32'(bus.req_ready), 32'b0010);
      tick();
      bus.req_valid = 4'b1100;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_hold_gnt", 32'(bus.req_ready), 32'd0);
         chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_hold_c", 32'(bus.rsp_c), 32'd225);
         chk("bp_hold_id", 32'(bus.rsp_id), 32'd0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_rel_gnt2", 32'(bus.req_ready), 32'b0100);
      tick();
      bus.req_valid = 4'b1000;
      chk("bp_d1_c", 32'(bus.rsp_c), 32'd0);
      chk("bp_d1_id", 32'(bus.rsp_id), 32'd1);
      #1;
      chk("bp_rel_gnt3", 32'(bus.req_ready), 32'b1000);
      tick();
      bus.req_valid = '0;
      chk("bp_d2_c", 32'(bus.rsp_c), 32'd56);
      chk("bp_d2_id", 32'(bus.rsp_id), 32'd2);
      tick();
      chk("bp_d3_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_d3_c", 32'(bus.rsp_c), 32'd15);
      chk("bp_d3_id", 32'(bus.rsp_id), 32'd3);
      tick();
      chk("bp_empty", 32'(bus.rsp_valid), 32'd0);
      chk("bp_ops", 32'(ops_done), 32'd8);

      // fairness between requesters 0 and 3
      cnt0 = 0;
      cnt3 = 0;
      bus.req_valid = 4'b1001;
      for (int g = 0; g < 20; g++) begin
         #1;
         oh = (g % 2 == 0) ? 4'b0001 : 4'b1000;
         chk("fair_gnt", 32'(bus.req_ready), 32'(oh));
         if (bus.req_ready[0]) cnt0++;
         if (bus.req_ready[3]) cnt3++;
         tick();
      end
      bus.req_valid = '0;
      chk("fair_cnt0", 32'(cnt0), 32'd10);
      chk("fair_cnt3", 32'(cnt3), 32'd10);
      tick();
      tick();
      chk("fair_ops", 32'(ops_done), 32'd28);

      // 4-bit counter wraps after 16
      bus4.rsp_ready = 1'b1;
      bus4.req_a[3:0] = 4'd15;
      bus4.req_b[3:0] = 4'd15;
      bus4.req_valid = 4'b0001;
      repeat (17) tick();
      bus4.req_valid = '0;
      repeat (3) tick();
      chk("wrap_ops", 32'(ops_done4), 32'd1);
      chk("wrap_c", 32'(bus4.rsp_c), 32'd225);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
